// File: rtl/pcie_rx_cpl.sv
// rtl/pcie_rx_cpl.sv - Receive completion decoder.
// Turns inbound 256-bit TLP beats into AXI4 R-channel beats. Flags malformed completions and drops non-completions.
module pcie_rx_cpl #(
  parameter int PAYLOAD_WIDTH = 256,
  parameter int ID_WIDTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tlp_in_valid,
  output logic                     tlp_in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] tlp_in_data,
  input  logic                     tlp_in_last,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [PAYLOAD_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]      rid,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     cpl_err,
  output logic                     tlp_drop
);

  localparam int CW = PAYLOAD_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic                       r_rvalid;
  logic [PAYLOAD_WIDTH-1:0]   r_rdata;
  logic [ID_WIDTH-1:0]        r_rid;
  logic [1:0]                 r_rresp;
  logic                       r_rlast;
  logic                       r_cpl_err;
  logic                       r_tlp_drop;

  logic [CW-1:0]              r_acc_lo;
  logic [8:0]                 r_cnt;
  logic [8:0]                 r_exp;
  logic [1:0]                 r_resp;
  logic [ID_WIDTH-1:0]        r_id;

  logic [CW-1:0]              w_hdr;
  logic [CW-1:0]              w_chunk;
  logic                       w_unused_hdr;
  logic [2:0]                 w_fmt;
  logic [4:0]                 w_type;
  logic [9:0]                 w_len;
  logic [2:0]                 w_status;
  logic [ID_WIDTH-1:0]        w_tag_id;
  logic                       w_is_cpld;
  logic                       w_is_cpl;
  logic [8:0]                 w_hdr_chunks;
  logic                       w_r_free;
  logic                       w_accept;
  logic                       w_in_idle;
  logic                       w_chunk_take;
  logic [8:0]                 w_idx;
  logic [8:0]                 w_exp;
  logic [1:0]                 w_resp_ok;
  logic [ID_WIDTH-1:0]        w_id;
  logic                       w_final;
  logic                       w_early;
  logic                       w_over;
  logic                       w_emit;

  logic                       w_load;
  logic [PAYLOAD_WIDTH-1:0]   w_ld_data;
  logic                       w_ld_last;
  logic [1:0]                 w_ld_resp;
  logic                       w_err;
  logic                       w_drop;
  logic                       w_store_lo;
  logic                       w_latch_hdr;

  assign w_hdr        = tlp_in_data[PAYLOAD_WIDTH-1:CW];
  assign w_chunk      = tlp_in_data[CW-1:0];
  assign w_unused_hdr = ^w_hdr;
  assign w_fmt        = w_hdr[127:125];
  assign w_type       = w_hdr[124:120];
  assign w_len        = w_hdr[105:96];
  assign w_status     = w_hdr[79:77];
  assign w_tag_id     = w_hdr[40 +: ID_WIDTH];

  assign w_is_cpld = (w_fmt == 3'b010) && (w_type == 5'b01010);
  assign w_is_cpl  = (w_fmt == 3'b000) && (w_type == 5'b01010);

  // ceil(Length/4) in 128-bit chunks; Length 0 encodes 1024 DW
  assign w_hdr_chunks = (w_len == 10'd0) ? 9'd256
                      : ({1'b0, w_len[9:2]} + {8'd0, |w_len[1:0]});

  assign w_r_free     = !r_rvalid || rready;
  assign tlp_in_ready = !rst && ((r_state == ST_DROP) || w_r_free);
  assign w_accept     = tlp_in_valid && tlp_in_ready;

  // In IDLE the chunk context comes straight from the header being accepted
  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_chunk_take = w_accept && ((w_in_idle && w_is_cpld) || (r_state == ST_DATA));
  assign w_idx        = w_in_idle ? 9'd0 : r_cnt;
  assign w_exp        = w_in_idle ? w_hdr_chunks : r_exp;
  assign w_resp_ok    = w_in_idle ? ((w_status == 3'b000) ? 2'b00 : 2'b10) : r_resp;
  assign w_id         = w_in_idle ? w_tag_id : r_id;
  assign w_final      = ((w_idx + 9'd1) == w_exp);
  assign w_early      = tlp_in_last && !w_final;
  assign w_over       = w_final && !tlp_in_last;
  assign w_emit       = w_idx[0] || w_final || tlp_in_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ld_data   = '0;
    w_ld_last   = 1'b0;
    w_ld_resp   = 2'b00;
    w_err       = 1'b0;
    w_drop      = 1'b0;
    w_store_lo  = 1'b0;
    w_latch_hdr = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_cpld) begin
            w_latch_hdr = 1'b1;
          end else if (w_is_cpl) begin
            w_load      = 1'b1;
            w_ld_last   = 1'b1;
            w_ld_resp   = w_resp_ok;
            w_err       = !tlp_in_last;
            w_state_nxt = tlp_in_last ? ST_IDLE : ST_DROP;
          end else begin
            w_drop      = 1'b1;
            w_state_nxt = tlp_in_last ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_DATA: begin
        w_state_nxt = ST_DATA;
      end
      ST_DROP: begin
        if (w_accept && tlp_in_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Payload chunk handling shared by the first CplD beat and DATA beats
    if (w_chunk_take) begin
      w_load     = w_emit;
      w_ld_data  = w_idx[0] ? {w_chunk, r_acc_lo} : {{CW{1'b0}}, w_chunk};
      w_ld_last  = w_final || tlp_in_last;
      w_ld_resp  = w_early ? 2'b10 : w_resp_ok;
      w_err      = w_early || w_over;
      w_store_lo = !w_emit;
      if (w_final || tlp_in_last) begin
        w_state_nxt = tlp_in_last ? ST_IDLE : ST_DROP;
      end else begin
        w_state_nxt = ST_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rid      <= '0;
      r_rresp    <= 2'b00;
      r_rlast    <= 1'b0;
      r_cpl_err  <= 1'b0;
      r_tlp_drop <= 1'b0;
      r_acc_lo   <= '0;
      r_cnt      <= 9'd0;
      r_exp      <= 9'd0;
      r_resp     <= 2'b00;
      r_id       <= '0;
    end else begin
      r_cpl_err  <= w_err;
      r_tlp_drop <= w_drop;

      if (w_load) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_ld_data;
        r_rid    <= w_id;
        r_rresp  <= w_ld_resp;
        r_rlast  <= w_ld_last;
      end else if (rready) begin
        r_rvalid <= 1'b0;
      end

      if (w_store_lo) begin
        r_acc_lo <= w_chunk;
      end
      if (w_chunk_take) begin
        r_cnt <= w_idx + 9'd1;
      end
      if (w_latch_hdr) begin
        r_exp  <= w_hdr_chunks;
        r_resp <= w_resp_ok;
        r_id   <= w_tag_id;
      end
    end
  end

  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign rid      = r_rid;
  assign rresp    = r_rresp;
  assign rlast    = r_rlast;
  assign cpl_err  = r_cpl_err;
  assign tlp_drop = r_tlp_drop;

endmodule

// File: tb/tb_pcie_rx_cpl.sv
// tb/tb_pcie_rx_cpl.sv - Randomized self-checking bench for pcie_rx_cpl.
// Expected R beats and pulses come from a per-TLP model of the completion rules.
module tb_pcie_rx_cpl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tlp_in_valid = 1'b0;
  logic         tlp_in_ready;
  logic [255:0] tlp_in_data = '0;
  logic         tlp_in_last = 1'b0;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [255:0] rdata;
  logic [3:0]   rid;
  logic [1:0]   rresp;
  logic         rlast;
  logic         cpl_err;
  logic         tlp_drop;

  always #5 clk = ~clk;

  pcie_rx_cpl #(.PAYLOAD_WIDTH(256), .ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .tlp_in_valid(tlp_in_valid), .tlp_in_ready(tlp_in_ready),
    .tlp_in_data(tlp_in_data), .tlp_in_last(tlp_in_last),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rresp(rresp), .rlast(rlast), .cpl_err(cpl_err), .tlp_drop(tlp_drop)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [3:0]   id;
    logic [1:0]   resp;
    logic         last;
  } rbeat_t;

  rbeat_t       exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           rready_mode = 0;
  int           block_cnt = 0;
  bit           hold_v = 0;
  rbeat_t       held;
  int           r_seen = 0;
  int           err_seen = 0;
  int           drop_seen = 0;
  rbeat_t       last_r;
  logic [127:0] chunk_log [0:299];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // One clock: drive rready, sample handshakes just before the edge, check pulses after it
  task automatic cycle(input bit b_emit, input bit b_err, input bit b_drop, input bit b_indrop,
                       output bit acc);
    rbeat_t e;
    bit     ex_ready;
    if (block_cnt > 0 && rvalid) begin
      rready = 1'b0;
      block_cnt--;
    end else if (rready_mode == 1) begin
      rready = ($urandom_range(0, 2) != 0);
    end else begin
      rready = 1'b1;
    end
    #4;
    ex_ready = rst ? 1'b0 : (b_indrop ? 1'b1 : !(rvalid && !rready));
    chk("tlp_in_ready", tlp_in_ready, ex_ready);
    if (!rst) begin
      if (hold_v) begin
        chk("rvalid_held", rvalid, 1);
        chk("rdata_stable", rdata, held.data);
        chk("rid_stable", rid, held.id);
        chk("rresp_stable", rresp, held.resp);
        chk("rlast_stable", rlast, held.last);
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_beat: unexpected beat rdata=%h, required no beat", rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", rdata, e.data);
          chk("rid", rid, e.id);
          chk("rresp", rresp, e.resp);
          chk("rlast", rlast, e.last);
        end
        last_r = '{data: rdata, id: rid, resp: rresp, last: rlast};
        r_seen++;
        hold_v = 0;
      end else if (rvalid) begin
        hold_v = 1;
        held = '{data: rdata, id: rid, resp: rresp, last: rlast};
      end else begin
        hold_v = 0;
      end
    end else begin
      hold_v = 0;
    end
    acc = tlp_in_valid && tlp_in_ready && !rst;
    @(negedge clk);
    if (cpl_err === 1'b1) err_seen++;
    if (tlp_drop === 1'b1) drop_seen++;
    chk("cpl_err", cpl_err, acc && b_err);
    chk("tlp_drop", tlp_drop, acc && b_drop);
    if (acc && b_emit) chk("rvalid_latency", rvalid, 1);
  endtask

  task automatic send_beat(input logic [255:0] d, input bit lst, input bit e_emit,
                           input bit e_err, input bit e_drop, input bit e_indrop);
    bit acc;
    int n = 0;
    tlp_in_valid = 1'b1;
    tlp_in_data  = d;
    tlp_in_last  = lst;
    do begin
      cycle(e_emit, e_err, e_drop, e_indrop, acc);
      n++;
      if (!acc && n >= 1000) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout: not accepted after %0d cycles, required acceptance", n);
        finish_sim();
        return;
      end
    end while (!acc);
    tlp_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    tlp_in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, acc);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    tlp_in_valid = 1'b0;
    while ((exp_q.size() != 0 || rvalid) && n < 2000) begin
      cycle(0, 0, 0, 0, acc);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d R beats outstanding, required 0", exp_q.size());
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: derive every expected R beat and per-beat event from the TLP contents, then drive it
  task automatic send_tlp(input logic [2:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                          input logic [7:0] tag, input logic [2:0] st, input int nb);
    bit           is_cpld, is_cpl;
    int           ldw, nexp, used;
    logic [1:0]   resp_st;
    logic [127:0] hdr;
    bit           em [300];
    bit           er [300];
    bit           dr [300];
    bit           ind [300];
    rbeat_t       e;
    is_cpld = (fmt == 3'b010) && (typ == 5'b01010);
    is_cpl  = (fmt == 3'b000) && (typ == 5'b01010);
    resp_st = (st == 3'b000) ? 2'b00 : 2'b10;
    for (int j = 0; j < 300; j++) begin
      em[j] = 0; er[j] = 0; dr[j] = 0; ind[j] = 0;
      chunk_log[j] = rand128();
    end
    if (is_cpld) begin
      ldw  = (len == 10'd0) ? 1024 : int'(len);
      nexp = (ldw + 3) / 4;
      used = (nb < nexp) ? nb : nexp;
      for (int c = 0; c < used; c++) begin
        if (c % 2 == 1 || c == used - 1) begin
          em[c]  = 1;
          e.data = (c % 2 == 1) ? {chunk_log[c], chunk_log[c-1]} : {128'd0, chunk_log[c]};
          e.id   = tag[3:0];
          e.last = (c == used - 1);
          e.resp = (c == used - 1 && nb < nexp) ? 2'b10 : resp_st;
          exp_q.push_back(e);
        end
      end
      if (nb < nexp) er[nb-1] = 1;
      if (nb > nexp) er[nexp-1] = 1;
      for (int j = nexp; j < nb; j++) ind[j] = 1;
    end else if (is_cpl) begin
      em[0] = 1;
      e = '{data: 256'd0, id: tag[3:0], resp: resp_st, last: 1'b1};
      exp_q.push_back(e);
      er[0] = (nb > 1);
      for (int j = 1; j < nb; j++) ind[j] = 1;
    end else begin
      dr[0] = 1;
      for (int j = 1; j < nb; j++) ind[j] = 1;
    end
    hdr = rand128();
    hdr[127:125] = fmt;
    hdr[124:120] = typ;
    hdr[105:96]  = len;
    hdr[79:77]   = st;
    hdr[47:40]   = tag;
    for (int j = 0; j < nb; j++) begin
      send_beat({(j == 0) ? hdr : rand128(), chunk_log[j]}, (j == nb - 1), em[j], er[j], dr[j], ind[j]);
    end
  endtask

  initial begin
    bit           acc;
    int           r0, e0, d0, kind, nexp, nb, sel;
    logic [9:0]   len;
    logic [7:0]   tag;
    logic [2:0]   st, fmt;
    logic [4:0]   typ;
    logic [127:0] hdr;

    @(negedge clk);
    cycle(0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, acc);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rid", rid, 0);
    chk("reset_rresp", rresp, 0);
    chk("reset_rlast", rlast, 0);
    rst = 1'b0;
    idle(2);

    // Two-beat CplD packs into one R beat
    r0 = r_seen;
    send_tlp(3'b010, 5'b01010, 10'd8, 8'h03, 3'b000, 2);
    drain();
    chk("t1_beats", r_seen - r0, 1);
    chk("t1_rdata", last_r.data, {chunk_log[1], chunk_log[0]});
    chk("t1_rid", last_r.id, 4'h3);
    chk("t1_rresp", last_r.resp, 2'b00);
    chk("t1_rlast", last_r.last, 1);

    // Single-beat CplD leaves the upper half zero
    send_tlp(3'b010, 5'b01010, 10'd4, 8'h01, 3'b000, 1);
    drain();
    chk("t2_rdata", last_r.data, {128'd0, chunk_log[0]});
    chk("t2_rlast", last_r.last, 1);

    // Cpl with error status
    e0 = err_seen;
    send_tlp(3'b000, 5'b01010, 10'd1, 8'h05, 3'b001, 1);
    drain();
    chk("t3_rdata", last_r.data, 0);
    chk("t3_rresp", last_r.resp, 2'b10);
    chk("t3_rid", last_r.id, 4'h5);
    chk("t3_cpl_err", err_seen - e0, 0);

    // MWr is discarded
    r0 = r_seen;
    d0 = drop_seen;
    send_tlp(3'b011, 5'b00000, 10'd8, 8'h02, 3'b000, 3);
    drain();
    chk("t4_drops", drop_seen - d0, 1);
    chk("t4_beats", r_seen - r0, 0);

    // Backpressure on R while a 4-chunk CplD streams in
    r0 = r_seen;
    block_cnt = 5;
    send_tlp(3'b010, 5'b01010, 10'd16, 8'h0A, 3'b000, 4);
    drain();
    chk("t5_blocked", block_cnt, 0);
    chk("t5_beats", r_seen - r0, 2);
    chk("t5_rdata", last_r.data, {chunk_log[3], chunk_log[2]});
    chk("t5_rlast", last_r.last, 1);

    // Early last
    e0 = err_seen;
    send_tlp(3'b010, 5'b01010, 10'd12, 8'h07, 3'b000, 2);
    drain();
    chk("t6_rresp", last_r.resp, 2'b10);
    chk("t6_rlast", last_r.last, 1);
    chk("t6_cpl_err", err_seen - e0, 1);
    send_tlp(3'b010, 5'b01010, 10'd8, 8'h09, 3'b000, 2);
    drain();
    chk("t6_next_rid", last_r.id, 4'h9);
    chk("t6_next_rdata", last_r.data, {chunk_log[1], chunk_log[0]});

    // Reset in the middle of a CplD
    r0 = r_seen;
    hdr = rand128();
    hdr[127:125] = 3'b010;
    hdr[124:120] = 5'b01010;
    hdr[105:96]  = 10'd12;
    hdr[47:40]   = 8'h0C;
    send_beat({hdr, rand128()}, 1'b0, 0, 0, 0, 0);
    rst = 1'b1;
    tlp_in_valid = 1'b1;
    tlp_in_data = {rand128(), rand128()};
    cycle(0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, acc);
    rst = 1'b0;
    tlp_in_valid = 1'b0;
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_rid", rid, 0);
    chk("rst_mid_rlast", rlast, 0);
    idle(4);
    chk("rst_mid_beats", r_seen - r0, 0);
    send_tlp(3'b010, 5'b01010, 10'd8, 8'h06, 3'b000, 2);
    drain();
    chk("rst_mid_next_rdata", last_r.data, {chunk_log[1], chunk_log[0]});

    // Overlong TLP and Length=0 (1024 DW)
    e0 = err_seen;
    send_tlp(3'b010, 5'b01010, 10'd4, 8'h04, 3'b000, 3);
    drain();
    chk("overlong_cpl_err", err_seen - e0, 1);
    r0 = r_seen;
    send_tlp(3'b010, 5'b01010, 10'd0, 8'h0F, 3'b000, 256);
    drain();
    chk("len0_beats", r_seen - r0, 128);

    // Randomized mix, mostly back-to-back
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 99);
      rready_mode = $urandom_range(0, 1);
      tag = 8'($urandom);
      st = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      if (kind < 55) begin
        len = 10'($urandom_range(1, 40));
        nexp = (int'(len) + 3) / 4;
        sel = $urandom_range(0, 9);
        nb = nexp;
        if (sel < 2 && nexp > 1) nb = $urandom_range(1, nexp - 1);
        else if (sel < 4) nb = nexp + $urandom_range(1, 3);
        send_tlp(3'b010, 5'b01010, len, tag, st, nb);
      end else if (kind < 75) begin
        nb = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
        send_tlp(3'b000, 5'b01010, 10'($urandom), tag, st, nb);
      end else begin
        fmt = 3'($urandom);
        typ = 5'($urandom);
        while (typ == 5'b01010 && (fmt == 3'b010 || fmt == 3'b000)) begin
          fmt = 3'($urandom);
          typ = 5'($urandom);
        end
        send_tlp(fmt, typ, 10'($urandom), tag, st, $urandom_range(1, 4));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rready_mode = 0;
    drain();
    chk("exp_queue_empty", exp_q.size(), 0);
    finish_sim();
  end

endmodule
